// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, block type and sequencer state encodings
//
// Purpose: common definitions for the AES inverse-cipher control path.
// Ports:   none (package).
package aes_pkg;

    localparam int AES_NR256 = 14;
    localparam int AES_BLK_W = 128;

    typedef logic [AES_BLK_W-1:0] aes_block_t;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/aes_round_counter.sv
// rtl/aes_round_counter.sv - loadable down-counter with terminal flag for round sequencing
//
// Purpose: holds the current round-key index while rounds are being applied.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (has priority over dec)
//   load_val in   W  value to load
//   dec      in   decrement by one this cycle
//   cnt      out  W  current count
//   at_one   out  count equals 1 (last full round before the final round)
module aes_round_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         at_one
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign at_one = (cnt == W'(1));

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// rtl/aes_inv_round_ctrl.sv - iterative AES inverse-cipher sequencer, one round per clock
//
// Purpose: owns the state register, round counter and handshakes; the inverse-round
// datapath and the expanded key store sit outside this block.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   key_ready           key store holds a valid schedule
//   in_valid/in_ready   ciphertext handshake, in_data = ciphertext block
//   key_idx             round-key index to key store; round_key = its read data
//   rnd_state           state register to the datapath
//   rnd_last            final round: datapath skips inverse mixcolumns
//   rnd_result          datapath output for rnd_state/round_key
//   out_valid/out_ready plaintext handshake, out_data = plaintext block
//   busy                block in flight (accept until output handshake)
module aes_inv_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR256,
    parameter int KIDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic [KIDX_W-1:0]    key_idx,
    input  logic [AES_BLK_W-1:0] round_key,
    output logic [AES_BLK_W-1:0] rnd_state,
    output logic                 rnd_last,
    input  logic [AES_BLK_W-1:0] rnd_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 busy
);

    logic [1:0]        fsm;
    aes_block_t        state_q;
    logic [KIDX_W-1:0] cnt;
    logic              cnt_one;
    logic              accept;

    // in_ready is forced low during the reset cycle itself
    assign in_ready = !rst && (fsm == ST_IDLE) && key_ready;
    assign accept   = in_valid && in_ready;

    aes_round_counter #(.W(KIDX_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (KIDX_W'(NR - 1)),
        .dec      (fsm == ST_ROUND),
        .cnt      (cnt),
        .at_one   (cnt_one)
    );

    // IDLE presents the last round key so the initial AddRoundKey can be
    // folded into the accept cycle
    always_comb begin
        key_idx = '0;
        case (fsm)
            ST_IDLE:  key_idx = KIDX_W'(NR);
            ST_ROUND: key_idx = cnt;
            default:  key_idx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= ST_IDLE;
            state_q <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= in_data ^ round_key;
                        fsm     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    state_q <= rnd_result;
                    if (cnt_one) begin
                        fsm <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    state_q <= rnd_result;
                    fsm     <= ST_DONE;
                end
                default: begin
                    // DONE: hold the plaintext until the consumer takes it
                    if (out_ready) begin
                        fsm <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign rnd_state = state_q;
    assign rnd_last  = (fsm == ST_FINAL);
    assign out_valid = (fsm == ST_DONE);
    assign out_data  = state_q;
    assign busy      = (fsm != ST_IDLE);

endmodule
